// File: rtl/gate_pkg.sv
// gate_pkg: shared definitions for the pipelined gate unit.
//   - OP_* : 3-bit gate-select encodings
//   - MAX_W: widest operand gate_eval handles; narrower operands are zero-extended
//   - gate_eval(a, b, op): combinational bitwise gate function
package gate_pkg;

    localparam int unsigned MAX_W = 64;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOT  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    // Strictly bitwise: no bit of the result depends on any other bit position.
    function automatic logic [MAX_W-1:0] gate_eval(input logic [MAX_W-1:0] a,
                                                   input logic [MAX_W-1:0] b,
                                                   input logic [2:0]       op);
        logic [MAX_W-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            OP_NOT:  r = ~a;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipe_slice.sv
// pipe_slice: one elastic valid/ready register stage.
//   clk, rst            : clock, synchronous active-high reset
//   up_valid/up_ready   : upstream handshake, up_data captured on up_valid && up_ready
//   dn_valid/dn_ready   : downstream handshake, dn_data is the held register
// up_ready is combinational from dn_ready so a full stage draining this cycle can
// refill in the same cycle (no bubble).
module pipe_slice
    import gate_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [DW-1:0] up_data,
    output logic          dn_valid,
    input  logic          dn_ready,
    output logic [DW-1:0] dn_data
);

    logic          valid_q;
    logic [DW-1:0] data_q;

    // Free if empty, or if the current occupant leaves this cycle.
    assign up_ready = !valid_q || dn_ready;
    assign dn_valid = valid_q;
    assign dn_data  = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (up_ready) begin
                valid_q <= up_valid;
            end
            // Data only moves on a real handshake so y holds when the pipe empties.
            if (up_valid && up_ready) begin
                data_q <= up_data;
            end
        end
    end

endmodule

// File: rtl/gate_unit_pipe.sv
// gate_unit_pipe: WIDTH-bit bitwise logic unit with eight gate functions behind a
// STAGES-deep valid/ready elastic pipeline, plus result reduction flags and a
// completed-transaction counter.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid, in_ready   : input handshake for a, b, op
//   op, a, b             : gate select and operands
//   out_valid, out_ready : output handshake for y, y_all, y_any
//   y, y_all, y_any      : result, AND-reduction, OR-reduction
//   txn_count            : output handshakes since reset, wraps at 2^CNT_W
module gate_unit_pipe
    import gate_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_all,
    output logic             y_any,
    output logic [CNT_W-1:0] txn_count
);

    logic [MAX_W-1:0] a_ext;
    logic [MAX_W-1:0] b_ext;
    logic [MAX_W-1:0] res_ext;
    logic [WIDTH-1:0] res;

    always_comb begin
        a_ext              = '0;
        b_ext              = '0;
        a_ext[WIDTH-1:0]   = a;
        b_ext[WIDTH-1:0]   = b;
        res_ext            = gate_eval(a_ext, b_ext, op);
    end

    assign res = res_ext[WIDTH-1:0];

    // Bits above WIDTH come from zero-extended operands and are discarded.
    if (WIDTH < MAX_W) begin : g_res_hi
        logic unused_res_hi;
        assign unused_res_hi = ^res_ext[MAX_W-1:WIDTH];
    end

    // Each stage has its own handshake signals; the ready chain runs from out_ready
    // back to in_ready through every stage combinationally.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             up_valid;
        logic             up_ready;
        logic [WIDTH-1:0] up_data;
        logic             dn_valid;
        logic             dn_ready;
        logic [WIDTH-1:0] dn_data;

        if (i == 0) begin : g_src
            assign up_valid = in_valid;
            assign up_data  = res;
        end else begin : g_src
            assign up_valid = g_stage[i-1].dn_valid;
            assign up_data  = g_stage[i-1].dn_data;
        end

        if (i == STAGES - 1) begin : g_snk
            // Final stage carries {y_any, y_all, y}; reductions are taken on the way
            // in so they register alongside y with no extra latency.
            logic [WIDTH+1:0] fin_data;

            assign dn_ready = out_ready;

            pipe_slice #(
                .DW(WIDTH + 2)
            ) u_slice (
                .clk      (clk),
                .rst      (rst),
                .up_valid (up_valid),
                .up_ready (up_ready),
                .up_data  ({|up_data, &up_data, up_data}),
                .dn_valid (dn_valid),
                .dn_ready (dn_ready),
                .dn_data  (fin_data)
            );

            assign dn_data = fin_data[WIDTH-1:0];
            assign y_all   = fin_data[WIDTH];
            assign y_any   = fin_data[WIDTH+1];
        end else begin : g_snk
            assign dn_ready = g_stage[i+1].up_ready;

            pipe_slice #(
                .DW(WIDTH)
            ) u_slice (
                .clk      (clk),
                .rst      (rst),
                .up_valid (up_valid),
                .up_ready (up_ready),
                .up_data  (up_data),
                .dn_valid (dn_valid),
                .dn_ready (dn_ready),
                .dn_data  (dn_data)
            );
        end
    end

    assign in_ready  = g_stage[0].up_ready;
    assign out_valid = g_stage[STAGES-1].dn_valid;
    assign y         = g_stage[STAGES-1].dn_data;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (out_valid && out_ready) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign txn_count = cnt_q;

endmodule

// File: tb/tb_gate_unit_pipe.sv
// Bench for gate_unit_pipe (WIDTH=8, STAGES=2, CNT_W=4). A queue-of-items model
// tracks each accepted result's position in the pipe and is compared every cycle;
// directed scenarios add literal expectations on the observed output stream.
module tb_gate_unit_pipe;

    localparam int S  = 2;
    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [2:0]    op = 3'b000;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  y;
    logic          y_all;
    logic          y_any;
    logic [CW-1:0] txn_count;

    gate_unit_pipe #(
        .WIDTH  (W),
        .STAGES (S),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_all     (y_all),
        .y_any     (y_any),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_gate(input logic [2:0] o, input logic [7:0] x,
                                            input logic [7:0] z);
        case (o)
            3'd0:    return x & z;
            3'd1:    return x | z;
            3'd2:    return x ^ z;
            3'd3:    return ~(x & z);
            3'd4:    return ~(x | z);
            3'd5:    return ~(x ^ z);
            3'd6:    return ~x;
            default: return x;
        endcase
    endfunction

    // Model: in-flight results in order (oldest first) with their slot position.
    typedef struct {
        logic [7:0] d;
        int         pos;
    } item_t;

    item_t      mq[$];
    logic [7:0] last_y = '0;
    int         cnt = 0;
    bit         model_en = 1'b0;
    logic [9:0] obs[$];   // observed {y_any, y_all, y} per output handshake

    always @(negedge clk) begin : cmp
        bit    exp_ov;
        bit    exp_ir;
        int    lim;
        int    np;
        item_t it;

        exp_ov = (mq.size() > 0) && (mq[0].pos == S - 1);
        exp_ir = (mq.size() < S) || out_ready;

        if (model_en) begin
            chk("in_ready", in_ready, exp_ir);
            chk("out_valid", out_valid, exp_ov);
            chk("y", y, last_y);
            chk("y_all", y_all, &last_y);
            chk("y_any", y_any, |last_y);
            chk("txn_count", txn_count, cnt);
            if (!rst && out_valid && out_ready) obs.push_back({y_any, y_all, y});
        end

        if (rst) begin
            mq.delete();
            last_y   = '0;
            cnt      = 0;
            model_en = 1'b1;
        end else begin
            if (exp_ov && out_ready) begin
                void'(mq.pop_front());
                cnt = (cnt + 1) % (1 << CW);
            end
            lim = S - 1;
            for (int i = 0; i < mq.size(); i++) begin
                np = (mq[i].pos + 1 <= lim) ? mq[i].pos + 1 : mq[i].pos;
                if (np == S - 1 && mq[i].pos != S - 1) last_y = mq[i].d;
                mq[i].pos = np;
                lim = np - 1;
            end
            if (in_valid && exp_ir) begin
                it.d   = ref_gate(op, a, b);
                it.pos = 0;
                mq.push_back(it);
                if (S == 1) last_y = it.d;
            end
        end
    end

    // All drives happen 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] o, input logic [7:0] xa, input logic [7:0] xb);
        int n;
        op       = o;
        a        = xa;
        b        = xb;
        in_valid = 1'b1;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] sweep_exp [8];

    initial begin : stim
        sweep_exp = '{8'h88, 8'hEE, 8'h66, 8'h77, 8'h11, 8'h99, 8'h55, 8'hAA};

        // Reset
        rst       = 1'b1;
        out_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_y", y, 8'h00);
        chk("rst_txn", txn_count, 0);

        // Single AND, latency two cycles from accept
        step();
        send(3'b000, 8'hF0, 8'h3C);
        @(negedge clk);
        chk("lat_ov_early", out_valid, 1'b0);
        @(negedge clk);
        chk("lat_ov", out_valid, 1'b1);
        chk("lat_y", y, 8'h30);
        chk("lat_all", y_all, 1'b0);
        chk("lat_any", y_any, 1'b1);
        @(negedge clk);
        chk("lat_txn", txn_count, 1);

        // Back-to-back sweep of all ops
        step();
        obs.delete();
        for (int k = 0; k < 8; k++) send(3'(k), 8'hAA, 8'hCC);
        repeat (4) @(negedge clk);
        chk("sweep_count", obs.size(), 8);
        for (int k = 0; k < 8 && k < obs.size(); k++) chk("sweep_y", obs[k][7:0], sweep_exp[k]);
        chk("sweep_txn", txn_count, 9);   // 1 earlier + 8

        // Stall: fill with out_ready low, third input waits
        step();
        obs.delete();
        out_ready = 1'b0;
        send(3'b111, 8'h01, 8'h00);
        send(3'b111, 8'h02, 8'h00);
        fork
            send(3'b111, 8'h03, 8'h00);
            begin
                @(negedge clk);
                chk("stall_in_ready", in_ready, 1'b0);
                chk("stall_ov", out_valid, 1'b1);
                chk("stall_y", y, 8'h01);
                step();
                @(negedge clk);
                chk("stall_in_ready2", in_ready, 1'b0);
                chk("stall_y2", y, 8'h01);
                step();
                out_ready = 1'b1;
                @(negedge clk);
                chk("drain_in_ready", in_ready, 1'b1);
            end
        join
        repeat (4) @(negedge clk);
        chk("stall_count", obs.size(), 3);
        for (int k = 0; k < 3 && k < obs.size(); k++) chk("stall_order", obs[k][7:0], k + 1);

        // Reductions
        step();
        obs.delete();
        send(3'b111, 8'hFF, 8'h00);
        send(3'b000, 8'h00, 8'h00);
        repeat (4) @(negedge clk);
        chk("red_count", obs.size(), 2);
        if (obs.size() == 2) begin
            chk("red_ff", obs[0], {2'b11, 8'hFF});
            chk("red_00", obs[1], {2'b00, 8'h00});
        end

        // Reset with two results in flight and a simultaneous input
        step();
        obs.delete();
        send(3'b111, 8'h11, 8'h00);
        send(3'b111, 8'h22, 8'h00);
        rst      = 1'b1;
        in_valid = 1'b1;
        op       = 3'b111;
        a        = 8'h5A;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_ov", out_valid, 1'b0);
        chk("mid_rst_txn", txn_count, 0);
        chk("mid_rst_y", y, 8'h00);
        repeat (5) @(negedge clk);
        chk("mid_rst_no_stale", obs.size(), 0);

        // Counter wrap: 17 handshakes on a 4-bit counter
        step();
        for (int k = 0; k < 17; k++) send(3'b010, 8'(k), 8'h0F);
        repeat (4) @(negedge clk);
        chk("wrap_txn", txn_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
